// File: rtl/alu_pkg.sv
// Shared types for the ALU command path: operand widths, opcode encoding,
// the buffered command record and the dispatcher issue-register states.
package alu_pkg;

    localparam int unsigned OPC_W  = 3;
    localparam int unsigned DATA_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpAnd  = 3'd2,
        OpOr   = 3'd3,
        OpXor  = 3'd4,
        OpShl  = 3'd5,
        OpShr  = 3'd6,
        OpPass = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t             opcode;
        logic [DATA_W-1:0]   op1;
        logic [DATA_W-1:0]   op2;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StHold
    } disp_state_t;

    localparam alu_cmd_t CMD_RESET = '{opcode: OpAdd, op1: '0, op2: '0};

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of alu_cmd_t with wrap-bit pointers so that
// full/empty/count fall straight out of the pointer difference.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  alu_cmd_t                 wdata,
    output alu_cmd_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    alu_cmd_t        mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_cmd_dispatcher.sv
// Buffers ALU commands behind a valid/ready handshake and issues one per cycle
// onto a registered command port that freezes under alu_stall.
module alu_cmd_dispatcher
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPC_W-1:0]         in_opcode,
    input  logic [DATA_W-1:0]        in_op1,
    input  logic [DATA_W-1:0]        in_op2,
    input  logic                     flush,
    input  logic                     alu_stall,
    output logic                     alu_valid,
    output logic [OPC_W-1:0]         alu_opcode,
    output logic [DATA_W-1:0]        alu_op1,
    output logic [DATA_W-1:0]        alu_op2,
    output logic [$clog2(DEPTH):0]   count
);

    alu_cmd_t    in_cmd;
    alu_cmd_t    head;
    alu_cmd_t    issue_q;
    logic        valid_q;
    disp_state_t state;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign in_cmd = '{opcode: opcode_t'(in_opcode), op1: in_op1, op2: in_op2};

    // Ready is a function of stored occupancy only; a stall never reaches it.
    assign in_ready = rstn && !full;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = !alu_stall && !empty && !flush;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (in_cmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= StIdle;
            valid_q <= 1'b0;
            issue_q <= CMD_RESET;
        end else if (flush) begin
            state   <= StIdle;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StIssue, StHold: begin
                    if (alu_stall) begin
                        // An empty issue register has nothing to hold.
                        if (state != StIdle) state <= StHold;
                    end else if (pop) begin
                        issue_q <= head;
                        valid_q <= 1'b1;
                        state   <= StIssue;
                    end else begin
                        valid_q <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: begin
                    state   <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_valid  = valid_q;
    assign alu_opcode = issue_q.opcode;
    assign alu_op1    = issue_q.op1;
    assign alu_op2    = issue_q.op2;

endmodule
